// File: rtl/flt_serializer_pkg.sv
// -----------------------------------------------------------------------------
// flt_serializer_pkg
// Shared widths, FSM state encoding and the Adler-32 modular-add helper for
// the scanline serializer (flt_serializer) and its Adler-32 accumulator.
// Width macros may be overridden on the command line before this file.
// -----------------------------------------------------------------------------
`ifndef SIZE_W_WD
`define SIZE_W_WD 12
`endif
`ifndef SIZE_H_WD
`define SIZE_H_WD 12
`endif
`ifndef DATA_CHN_WD
`define DATA_CHN_WD 8
`endif
`ifndef DATA_PXL_WD
`define DATA_PXL_WD 32
`endif

package flt_serializer_pkg;

    localparam int DATA_THR    = 4;              // bytes per pixel word (RGBA8)
    localparam int SIZE_W_WD   = `SIZE_W_WD;
    localparam int SIZE_H_WD   = `SIZE_H_WD;
    localparam int DATA_CHN_WD = `DATA_CHN_WD;
    localparam int DATA_PXL_WD = `DATA_PXL_WD;
    localparam int FLT_TYPE_WD = 8;

    localparam logic [16:0] ADLER_MOD = 17'd65521;

    typedef logic [FLT_TYPE_WD-1:0] flt_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_SEND  = 2'd3
    } state_e;

    // Both operands are below the modulus, so one conditional subtract suffices.
    function automatic logic [15:0] adler_mod_add(input logic [15:0] x, input logic [15:0] y);
        logic [16:0] s;
        logic [16:0] r;
        s = {1'b0, x} + {1'b0, y};
        if (s >= ADLER_MOD) begin
            r = s - ADLER_MOD;
        end else begin
            r = s;
        end
        return r[15:0];
    endfunction

endpackage

// File: rtl/flt_serializer_if.sv
// -----------------------------------------------------------------------------
// flt_serializer_if
// Groups the filtered-FIFO read port and the byte-stream handshake.
//   master : the serializer (reads the FIFO, drives the byte stream)
//   slave  : FIFO + deflate side
// Signals:
//   fifo_flt_empty_i   FIFO empty
//   fifo_flt_rd_val_o  FIFO read strobe
//   fifo_flt_rd_dat_i  FIFO data, valid the cycle after the strobe
//   byt_val_o/byt_dat_o/byt_rdy_i  byte handshake
//   byt_lst_o/byt_eol_o            frame / scanline last-byte markers
// -----------------------------------------------------------------------------
interface flt_serializer_if;
    import flt_serializer_pkg::*;

    logic                   fifo_flt_empty_i;
    logic                   fifo_flt_rd_val_o;
    logic [DATA_PXL_WD-1:0] fifo_flt_rd_dat_i;
    logic                   byt_val_o;
    logic [DATA_CHN_WD-1:0] byt_dat_o;
    logic                   byt_rdy_i;
    logic                   byt_lst_o;
    logic                   byt_eol_o;

    modport master (
        input  fifo_flt_empty_i, fifo_flt_rd_dat_i, byt_rdy_i,
        output fifo_flt_rd_val_o, byt_val_o, byt_dat_o, byt_lst_o, byt_eol_o
    );

    modport slave (
        output fifo_flt_empty_i, fifo_flt_rd_dat_i, byt_rdy_i,
        input  fifo_flt_rd_val_o, byt_val_o, byt_dat_o, byt_lst_o, byt_eol_o
    );

endinterface

// File: rtl/flt_serializer_adler32_acc.sv
// -----------------------------------------------------------------------------
// flt_serializer_adler32_acc
// Running zlib Adler-32 over the emitted byte stream.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset (a=1, b=0)
//   i_init     restart the checksum (a=1, b=0)
//   i_en       one byte accepted this cycle
//   i_byte     the accepted byte
//   o_adler    {b[15:0], a[15:0]}
// -----------------------------------------------------------------------------
module flt_serializer_adler32_acc
    import flt_serializer_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        i_init,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_adler
);

    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] w_a_nxt;
    logic [15:0] w_b_nxt;

    // b accumulates the already-updated a.
    always_comb begin
        w_a_nxt = adler_mod_add(r_a, {8'd0, i_byte});
        w_b_nxt = adler_mod_add(r_b, w_a_nxt);
    end

    // a/b registers: init on frame start, update on each accepted byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_a <= 16'd1;
            r_b <= 16'd0;
        end else if (i_init) begin
            r_a <= 16'd1;
            r_b <= 16'd0;
        end else if (i_en) begin
            r_a <= w_a_nxt;
            r_b <= w_b_nxt;
        end else begin
            r_a <= r_a;
            r_b <= r_b;
        end
    end

    assign o_adler = {r_b, r_a};

endmodule

// File: rtl/flt_serializer.sv
// -----------------------------------------------------------------------------
// flt_serializer
// Drains the filtered-data FIFO (per scanline: one header word holding the
// filter type in [31:24], then cfg_w pixel words) and emits the PNG byte
// stream: type byte, then pixel bytes LSB first, over a valid/ready handshake.
// Optional feature macro: FLT_SERIALIZER_ADLER_EN (Adler-32 of the stream;
// when undefined adler_o is tied to 0).
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   cfg_w_i, cfg_h_i  image width/height (>=1), sampled at start_i
//   start_i           frame start pulse (honoured only when idle)
//   done_o            pulse the cycle after the frame's last byte handshake
//   bus               flt_serializer_if.master (FIFO read + byte stream)
//   adler_o           {b,a}, valid from done_o until the next start_i
// -----------------------------------------------------------------------------
module flt_serializer
    import flt_serializer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [SIZE_W_WD-1:0] cfg_w_i,
    input  logic [SIZE_H_WD-1:0] cfg_h_i,
    input  logic                 start_i,
    output logic                 done_o,
    flt_serializer_if.master     bus,
    output logic [31:0]          adler_o
);

    localparam logic [1:0] BYTE_IDX_LAST = 2'(DATA_THR - 1);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic [SIZE_W_WD-1:0]   r_cfg_w;
    logic [SIZE_H_WD-1:0]   r_cfg_h;
    logic [SIZE_W_WD:0]     r_cnt_w;     // 0 = header word, 1..w = pixel words
    logic [SIZE_H_WD-1:0]   r_cnt_h;
    logic [1:0]             r_idx;
    logic [DATA_PXL_WD-1:0] r_word;
    logic                   r_byt_val;
    logic [7:0]             r_byt_dat;
    logic                   r_byt_eol;
    logic                   r_byt_lst;
    logic                   r_done;

    logic                   w_start;
    logic                   w_hs;
    logic                   w_hdr;
    logic                   w_word_last;
    logic                   w_line_end;
    logic                   w_last_line;
    logic                   w_rd_val;
    logic [1:0]             w_idx_nxt;
    logic [7:0]             w_byte_nxt;
    logic                   w_eol_nxt;

    assign w_start     = (r_state == ST_IDLE) && start_i;
    assign w_hs        = r_byt_val && bus.byt_rdy_i;
    assign w_hdr       = (r_cnt_w == {(SIZE_W_WD+1){1'b0}});
    assign w_word_last = w_hdr || (r_idx == BYTE_IDX_LAST);
    assign w_line_end  = (r_cnt_w == {1'b0, r_cfg_w});
    assign w_last_line = (r_cnt_h == (r_cfg_h - SIZE_H_WD'(1'b1)));
    assign w_idx_nxt   = r_idx + 2'd1;
    assign w_eol_nxt   = !w_hdr && w_line_end && (w_idx_nxt == BYTE_IDX_LAST);

    // Byte of the held word that follows the one currently on the bus.
    always_comb begin
        w_byte_nxt = 8'd0;
        case (w_idx_nxt)
            2'd0:    w_byte_nxt = r_word[7:0];
            2'd1:    w_byte_nxt = r_word[15:8];
            2'd2:    w_byte_nxt = r_word[23:16];
            default: w_byte_nxt = r_word[31:24];
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) begin
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!bus.fifo_flt_empty_i) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_WAIT: begin
                w_state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (w_hs && w_word_last) begin
                    if (w_line_end && w_last_line) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end else begin
                    w_state_nxt = ST_SEND;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: the read strobe lasts exactly the one FETCH cycle that
    // sees data, because FETCH always leaves for WAIT in that case.
    always_comb begin
        w_rd_val = 1'b0;
        case (r_state)
            ST_FETCH: w_rd_val = !bus.fifo_flt_empty_i;
            default:  w_rd_val = 1'b0;
        endcase
    end

    // Datapath: config latch, line/word counters, held word and byte register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cfg_w   <= {SIZE_W_WD{1'b0}};
            r_cfg_h   <= {SIZE_H_WD{1'b0}};
            r_cnt_w   <= {(SIZE_W_WD+1){1'b0}};
            r_cnt_h   <= {SIZE_H_WD{1'b0}};
            r_idx     <= 2'd0;
            r_word    <= {DATA_PXL_WD{1'b0}};
            r_byt_val <= 1'b0;
            r_byt_dat <= 8'd0;
            r_byt_eol <= 1'b0;
            r_byt_lst <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_cfg_w <= cfg_w_i;
                        r_cfg_h <= cfg_h_i;
                        r_cnt_w <= {(SIZE_W_WD+1){1'b0}};
                        r_cnt_h <= {SIZE_H_WD{1'b0}};
                        r_idx   <= 2'd0;
                    end
                end
                ST_WAIT: begin
                    // Header words carry only the type byte in [31:24].
                    r_word    <= bus.fifo_flt_rd_dat_i;
                    r_idx     <= 2'd0;
                    r_byt_val <= 1'b1;
                    r_byt_dat <= w_hdr ? bus.fifo_flt_rd_dat_i[31:24] : bus.fifo_flt_rd_dat_i[7:0];
                    r_byt_eol <= 1'b0;
                    r_byt_lst <= 1'b0;
                end
                ST_SEND: begin
                    if (w_hs) begin
                        if (w_word_last) begin
                            r_byt_val <= 1'b0;
                            r_byt_dat <= 8'd0;
                            r_byt_eol <= 1'b0;
                            r_byt_lst <= 1'b0;
                            if (!w_line_end) begin
                                r_cnt_w <= r_cnt_w + {{SIZE_W_WD{1'b0}}, 1'b1};
                            end else if (!w_last_line) begin
                                r_cnt_w <= {(SIZE_W_WD+1){1'b0}};
                                r_cnt_h <= r_cnt_h + SIZE_H_WD'(1'b1);
                            end else begin
                                r_done <= 1'b1;
                            end
                        end else begin
                            r_idx     <= w_idx_nxt;
                            r_byt_dat <= w_byte_nxt;
                            r_byt_eol <= w_eol_nxt;
                            r_byt_lst <= w_eol_nxt && w_last_line;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.fifo_flt_rd_val_o = w_rd_val;
    assign bus.byt_val_o         = r_byt_val;
    assign bus.byt_dat_o         = r_byt_dat;
    assign bus.byt_eol_o         = r_byt_eol;
    assign bus.byt_lst_o         = r_byt_lst;
    assign done_o                = r_done;

`ifdef FLT_SERIALIZER_ADLER_EN
    logic [31:0] w_adler;
    logic        r_adler_vld;

    flt_serializer_adler32_acc u_adler (
        .clk     (clk),
        .rstn    (rstn),
        .i_init  (w_start),
        .i_en    (w_hs),
        .i_byte  (r_byt_dat),
        .o_adler (w_adler)
    );

    // Checksum becomes visible with done_o and is hidden again at the next start.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_adler_vld <= 1'b0;
        end else if (w_start) begin
            r_adler_vld <= 1'b0;
        end else if (w_hs && w_word_last && w_line_end && w_last_line) begin
            r_adler_vld <= 1'b1;
        end else begin
            r_adler_vld <= r_adler_vld;
        end
    end

    assign adler_o = r_adler_vld ? w_adler : 32'd0;
`else
    assign adler_o = 32'd0;
`endif

endmodule

// File: tb/tb_flt_serializer.sv
// -----------------------------------------------------------------------------
// tb_flt_serializer
// Directed bench for flt_serializer: a FIFO model feeds words, expected bytes
// (with eol/lst flags) and the expected Adler-32 are queued as each word is
// loaded, and the byte stream is compared against that queue on handshakes.
// -----------------------------------------------------------------------------
module tb_flt_serializer;
    import flt_serializer_pkg::*;

    typedef struct packed {
        logic [7:0] dat;
        logic       eol;
        logic       lst;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rstn;
    logic [SIZE_W_WD-1:0] cfg_w_i;
    logic [SIZE_H_WD-1:0] cfg_h_i;
    logic                 start_i;
    logic                 done_o;
    logic [31:0]          adler_o;

    flt_serializer_if bus();

    flt_serializer dut (
        .clk     (clk),
        .rstn    (rstn),
        .cfg_w_i (cfg_w_i),
        .cfg_h_i (cfg_h_i),
        .start_i (start_i),
        .done_o  (done_o),
        .bus     (bus),
        .adler_o (adler_o)
    );

    always #5 clk = ~clk;

`ifdef FLT_SERIALIZER_ADLER_EN
    localparam bit ADLER_ON = 1'b1;
`else
    localparam bit ADLER_ON = 1'b0;
`endif

    // FIFO model: data appears the cycle after the read strobe.
    logic [31:0] fifo_mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        stall_empty = 1'b0;

    assign bus.fifo_flt_empty_i = (rd_ptr == wr_ptr) || stall_empty;

    always @(posedge clk) begin
        if (bus.fifo_flt_rd_val_o) begin
            bus.fifo_flt_rd_dat_i <= fifo_mem[rd_ptr[9:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    exp_t exp_q[$];
    int   exp_a;
    int   exp_b;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic add_byte(input logic [7:0] b, input bit eol, input bit lst);
        exp_t e;
        e.dat = b;
        e.eol = eol;
        e.lst = lst;
        exp_q.push_back(e);
        exp_a = (exp_a + int'(b)) % 65521;
        exp_b = (exp_b + exp_a) % 65521;
    endtask

    task automatic add_word(input logic [31:0] word, input bit hdr, input bit eol_line, input bit last_line);
        fifo_mem[wr_ptr % 1024] = word;
        wr_ptr = wr_ptr + 1;
        if (hdr) begin
            add_byte(word[31:24], 1'b0, 1'b0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                add_byte(word[8*k +: 8], (k == 3) && eol_line, (k == 3) && eol_line && last_line);
            end
        end
    endtask

    // kind 0: 1x1 smoke frame, kind 1: 2x2 with types 01/04, kind 2: all 0xFF
    task automatic load_frame(input int w, input int h, input int kind);
        logic [31:0] hw;
        logic [31:0] pw;
        exp_a = 1;
        exp_b = 0;
        for (int y = 0; y < h; y++) begin
            case (kind)
                0:       hw = 32'h0000_0000;
                1:       hw = (y == 0) ? 32'h0100_0000 : 32'h0400_0000;
                default: hw = 32'hFF00_0000;
            endcase
            add_word(hw, 1'b1, 1'b0, 1'b0);
            for (int x = 1; x <= w; x++) begin
                case (kind)
                    0:       pw = 32'h0403_0201;
                    1:       pw = 32'hA0B0_C0D0 ^ 32'(y * 16 + x * 3 + 1);
                    default: pw = 32'hFFFF_FFFF;
                endcase
                add_word(pw, 1'b0, x == w, (x == w) && (y == h - 1));
            end
        end
    endtask

    // Runs one frame from start_i to done_o, comparing every handshake.
    task automatic run_frame(input string tag, input int w, input int h,
                             input int stall_at, input int stall_len,
                             input int empty_len, input int restart_at);
        int   hs_cnt = 0;
        int   stall_left = stall_len;
        int   n_done = 0;
        int   viol = 0;
        int   stall_rd = 0;
        int   stall_seen = 0;
        int   empty_cnt = 0;
        int   tail = 0;
        bit   strobe_seen = 1'b0;
        bit   restarted = 1'b0;
        bit   finished = 1'b0;
        exp_t e;

        @(negedge clk);
        cfg_w_i         = SIZE_W_WD'(w);
        cfg_h_i         = SIZE_H_WD'(h);
        start_i         = 1'b1;
        stall_empty     = (empty_len > 0);
        bus.byt_rdy_i   = 1'b1;
        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            if (restart_at >= 0 && hs_cnt == restart_at && !restarted) begin
                start_i   = 1'b1;
                cfg_w_i   = SIZE_W_WD'(w + 3);
                cfg_h_i   = SIZE_H_WD'(h + 2);
                restarted = 1'b1;
            end
            if (stall_at >= 0 && hs_cnt == stall_at && stall_left > 0) begin
                bus.byt_rdy_i = 1'b0;
                stall_left--;
            end else begin
                bus.byt_rdy_i = 1'b1;
            end
            if (empty_len > 0) begin
                if (strobe_seen) begin
                    stall_empty = 1'b1;
                    empty_cnt   = 0;
                    strobe_seen = 1'b0;
                end else if (stall_empty) begin
                    if (empty_cnt >= empty_len) stall_empty = 1'b0;
                    else empty_cnt++;
                end
            end
            #1;
            if (bus.fifo_flt_rd_val_o && bus.fifo_flt_empty_i) viol++;
            if (bus.fifo_flt_rd_val_o) strobe_seen = 1'b1;
            if (!bus.byt_rdy_i && bus.fifo_flt_rd_val_o) stall_rd++;
            if (done_o) n_done++;
            if (bus.byt_val_o) begin
                if (exp_q.size() == 0) begin
                    check({tag, ".extra_byte"}, {31'd0, bus.byt_val_o}, 32'd0);
                end else if (bus.byt_rdy_i) begin
                    e = exp_q.pop_front();
                    hs_cnt++;
                    check($sformatf("%s.byte%0d{dat,eol,lst}", tag, hs_cnt),
                          {22'd0, bus.byt_dat_o, bus.byt_eol_o, bus.byt_lst_o}, {22'd0, e});
                end else begin
                    stall_seen++;
                    check($sformatf("%s.hold%0d", tag, stall_seen), {24'd0, bus.byt_dat_o}, {24'd0, exp_q[0].dat});
                end
            end
            if (exp_q.size() == 0) begin
                tail++;
                if (tail >= 4) finished = 1'b1;
            end
        end
        bus.byt_rdy_i = 1'b1;
        stall_empty   = 1'b0;
        check({tag, ".bytes_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, ".done_pulses"}, 32'(n_done), 32'd1);
        check({tag, ".rd_while_empty"}, 32'(viol), 32'd0);
        if (stall_at >= 0) begin
            check({tag, ".stall_valid_cycles"}, 32'(stall_seen), 32'(stall_len));
            check({tag, ".rd_during_stall"}, 32'(stall_rd), 32'd0);
        end
        check({tag, ".adler"}, adler_o, ADLER_ON ? {exp_b[15:0], exp_a[15:0]} : 32'd0);
        exp_q.delete();
    endtask

    initial begin
        int act;
        rstn          = 1'b0;
        start_i       = 1'b0;
        cfg_w_i       = '0;
        cfg_h_i       = '0;
        bus.byt_rdy_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("reset.outputs", {19'd0, bus.byt_val_o, bus.byt_dat_o, bus.byt_lst_o, bus.byt_eol_o, done_o, bus.fifo_flt_rd_val_o}, 32'd0);
        check("reset.adler", adler_o, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("idle.outputs", {19'd0, bus.byt_val_o, bus.byt_dat_o, bus.byt_lst_o, bus.byt_eol_o, done_o, bus.fifo_flt_rd_val_o}, 32'd0);

        // 1x1 frame: 00 01 02 03 04
        load_frame(1, 1, 0);
        run_frame("s1_1x1", 1, 1, -1, 0, 0, -1);
        check("s1.adler_const", adler_o, ADLER_ON ? 32'h0019_000B : 32'd0);

        // 2x2 frame, 18 bytes, types at positions 1 and 10
        load_frame(2, 2, 1);
        run_frame("s2_2x2", 2, 2, -1, 0, 0, -1);

        // downstream stall of 5 cycles on the third pixel byte
        load_frame(2, 2, 1);
        run_frame("s3_stall", 2, 2, 3, 5, 0, -1);

        // FIFO empty for 10 cycles before each word
        load_frame(2, 2, 1);
        run_frame("s4_empty", 2, 2, -1, 0, 10, -1);

        // start_i re-pulsed mid-frame with another geometry: ignored
        load_frame(2, 2, 1);
        run_frame("s5_restart", 2, 2, -1, 0, 0, 2);

        // reset mid-frame
        load_frame(2, 2, 1);
        @(negedge clk);
        cfg_w_i = SIZE_W_WD'(2);
        cfg_h_i = SIZE_H_WD'(2);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (7) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("s5_rst.outputs", {19'd0, bus.byt_val_o, bus.byt_dat_o, bus.byt_lst_o, bus.byt_eol_o, done_o, bus.fifo_flt_rd_val_o}, 32'd0);
        check("s5_rst.adler", adler_o, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        act = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (bus.byt_val_o || bus.fifo_flt_rd_val_o || done_o) act++;
        end
        check("s5_rst.no_resume", 32'(act), 32'd0);
        wr_ptr = rd_ptr;
        exp_q.delete();

        // 8x8 frame of 0xFF: 264 bytes, exercises the modular wrap of a and b
        load_frame(8, 8, 2);
        run_frame("s6_ff", 8, 8, -1, 0, 0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
